// File: rtl/vehicle_request_gen_if.sv
// Signal bundle between the country-road vehicle detector and its surroundings:
// the raw loop sensor and lamp state in, the request / queue / state observation out.
interface vehicle_request_gen_if #(
  parameter int CNT_W = 4
);
  logic             loop_raw;
  logic [1:0]       cntry_road_signal;
  logic             x;
  logic [CNT_W-1:0] pending;
  logic [1:0]       state_out;

  // Environment side: drives the sensor and lamp, observes the request.
  modport master (
    output loop_raw,
    output cntry_road_signal,
    input  x,
    input  pending,
    input  state_out
  );

  // Detector side.
  modport slave (
    input  loop_raw,
    input  cntry_road_signal,
    output x,
    output pending,
    output state_out
  );
endinterface

// File: rtl/vehicle_request_gen.sv
// Country-road vehicle detector: synchronize and debounce the loop sensor, count waiting
// vehicles, and request service. Optional green force-out timer under `VREQ_MAXOUT_EN.
module vehicle_request_gen #(
  parameter int DEB_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 8,
  parameter int MAX_GREEN    = 32,
  parameter int REARM_CYCLES = 16,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vehicle_request_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2,
    REARM = 2'd3
  } state_t;

  localparam logic [1:0] LAMP_GREEN = 2'b10;

  localparam int DBW = $clog2(DEB_CYCLES + 1);
  localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int RAW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB_CYCLES);
  localparam logic [DRW-1:0] DRAIN_LAST = DRW'(DRAIN_CYCLES - 1);
  localparam logic [RAW-1:0] REARM_LAST = RAW'(REARM_CYCLES - 1);

  state_t           state_q,     state_d;
  logic             sync1_q,     sync1_d;
  logic             s2_q,        s2_d;
  logic             filt_q,      filt_d;
  logic [DBW-1:0]   deb_cnt_q,   deb_cnt_d;
  logic [CNT_W-1:0] pending_q,   pending_d;
  logic [DRW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [RAW-1:0]   rearm_cnt_q, rearm_cnt_d;

`ifdef VREQ_MAXOUT_EN
  localparam int SVW = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
  localparam logic [SVW-1:0] SERVE_LAST = SVW'(MAX_GREEN - 1);
  logic [SVW-1:0] serve_cnt_q, serve_cnt_d;
`else
  localparam int unused_max_green = MAX_GREEN;
`endif

  logic           arrival;
  logic           drain_tick;
  logic           drain_dec;
  logic           green;
  logic           force_out;
  logic           rearm_done;
  logic [DBW-1:0] deb_inc;

  always_comb begin
    sync1_d     = bus.loop_raw;
    s2_d        = sync1_q;
    filt_d      = filt_q;
    deb_cnt_d   = '0;
    pending_d   = pending_q;
    drain_cnt_d = '0;
    rearm_cnt_d = '0;
    state_d     = state_q;
    force_out   = 1'b0;
    deb_inc     = deb_cnt_q + DBW'(1);

    // A level change must persist for DEB_CYCLES consecutive samples before filt follows it.
    if (s2_q != filt_q) begin
      if (deb_inc == DEB_LAST) begin
        filt_d = s2_q;
      end else begin
        deb_cnt_d = deb_inc;
      end
    end

    arrival    = filt_d & ~filt_q;
    green      = (bus.cntry_road_signal == LAMP_GREEN);
    drain_tick = (state_q == SERVE) && (drain_cnt_q == DRAIN_LAST);
    drain_dec  = drain_tick && (pending_q != '0);
    rearm_done = (state_q == REARM) && (rearm_cnt_q == REARM_LAST);

    // Simultaneous arrival and discharge cancel; a full queue drops further arrivals.
    if (arrival && drain_dec) begin
      pending_d = pending_q;
    end else if (arrival && (pending_q != '1)) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (drain_dec) begin
      pending_d = pending_q - CNT_W'(1);
    end

`ifdef VREQ_MAXOUT_EN
    serve_cnt_d = '0;
    force_out   = (state_q == SERVE) && (serve_cnt_q == SERVE_LAST);
`endif

    unique case (state_q)
      IDLE:    if (pending_q != '0) state_d = REQ;
      REQ:     if (green) state_d = SERVE;
      SERVE:   if ((pending_q == '0) || !green || force_out) state_d = REARM;
      REARM:   if (rearm_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timers only run while their state persists, so they always start from zero on entry.
    if ((state_q == SERVE) && (state_d == SERVE)) begin
      drain_cnt_d = drain_tick ? '0 : drain_cnt_q + DRW'(1);
`ifdef VREQ_MAXOUT_EN
      serve_cnt_d = serve_cnt_q + SVW'(1);
`endif
    end

    if ((state_q == REARM) && (state_d == REARM)) begin
      rearm_cnt_d = rearm_cnt_q + RAW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      s2_q        <= 1'b0;
      filt_q      <= 1'b0;
      deb_cnt_q   <= '0;
      pending_q   <= '0;
      drain_cnt_q <= '0;
      rearm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      deb_cnt_q   <= deb_cnt_d;
      pending_q   <= pending_d;
      drain_cnt_q <= drain_cnt_d;
      rearm_cnt_q <= rearm_cnt_d;
    end
  end

`ifdef VREQ_MAXOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serve_cnt_q <= '0;
    end else begin
      serve_cnt_q <= serve_cnt_d;
    end
  end
`endif

  // Moore outputs straight from registers, so reset clears them without a clock edge.
  assign bus.x         = (state_q == REQ) || (state_q == SERVE);
  assign bus.pending   = pending_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_vehicle_request_gen.sv
// Directed bench for vehicle_request_gen: a vector table for the single-vehicle and glitch
// flow, then hand-written saturation, force-out, simultaneity and async-reset sequences.
module tb_vehicle_request_gen;

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b10;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  vehicle_request_gen_if #(.CNT_W(4)) bus ();

  vehicle_request_gen #(
    .DEB_CYCLES  (4),
    .DRAIN_CYCLES(8),
    .MAX_GREEN   (32),
    .REARM_CYCLES(16),
    .CNT_W       (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       loop;
    logic [1:0] lamp;
    int         cycles;
    logic       exp_x;
    logic [3:0] exp_pending;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl[14];

  // Driver tasks: inputs change and outputs are sampled 1ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic ex, input logic [3:0] ep,
                           input logic [1:0] es);
    check({name, ".x"},       int'(bus.x),         int'(ex));
    check({name, ".pending"}, int'(bus.pending),   int'(ep));
    check({name, ".state"},   int'(bus.state_out), int'(es));
  endtask

  task automatic do_reset();
    reset_n              = 1'b0;
    bus.loop_raw          = 1'b0;
    bus.cntry_road_signal = RED;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // One debounced vehicle: high long enough to be accepted, low long enough to re-arm filt.
  task automatic arrive_one();
    bus.loop_raw = 1'b1;
    step(7);
    bus.loop_raw = 1'b0;
    step(7);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // loop goes high just before edge k; pending at k+5, x at k+6, loop high 10 cycles total.
    tbl[0]  = '{1'b1, RED,   5,  1'b0, 4'd0, 2'd0};
    tbl[1]  = '{1'b1, RED,   1,  1'b0, 4'd1, 2'd0};
    tbl[2]  = '{1'b1, RED,   1,  1'b1, 4'd1, 2'd1};
    tbl[3]  = '{1'b1, RED,   3,  1'b1, 4'd1, 2'd1};
    tbl[4]  = '{1'b0, RED,   10, 1'b1, 4'd1, 2'd1};
    tbl[5]  = '{1'b0, GREEN, 1,  1'b1, 4'd1, 2'd2};
    tbl[6]  = '{1'b0, GREEN, 7,  1'b1, 4'd1, 2'd2};
    tbl[7]  = '{1'b0, GREEN, 1,  1'b1, 4'd0, 2'd2};
    tbl[8]  = '{1'b0, GREEN, 1,  1'b0, 4'd0, 2'd3};
    tbl[9]  = '{1'b0, RED,   15, 1'b0, 4'd0, 2'd3};
    tbl[10] = '{1'b0, RED,   1,  1'b0, 4'd0, 2'd0};
    // Green while idle must not produce a request or service.
    tbl[11] = '{1'b0, GREEN, 3,  1'b0, 4'd0, 2'd0};
    // Three-cycle glitch is rejected.
    tbl[12] = '{1'b1, RED,   3,  1'b0, 4'd0, 2'd0};
    tbl[13] = '{1'b0, RED,   10, 1'b0, 4'd0, 2'd0};

    do_reset();
    check_all("reset", 1'b0, 4'd0, 2'd0);

    for (int i = 0; i < 14; i++) begin
      bus.loop_raw          = tbl[i].loop;
      bus.cntry_road_signal = tbl[i].lamp;
      step(tbl[i].cycles);
      check_all($sformatf("vec%0d", i), tbl[i].exp_x, tbl[i].exp_pending, tbl[i].exp_state);
    end

    // Saturation: 20 arrivals with no green, counter stops at 15.
    for (int i = 0; i < 20; i++) arrive_one();
    check_all("sat", 1'b1, 4'd15, 2'd1);
    step(20);
    check_all("sat_hold", 1'b1, 4'd15, 2'd1);

    // Green with a full queue: entry, then the 32-cycle boundary.
    bus.cntry_road_signal = GREEN;
    step(1);
    check_all("fo_entry", 1'b1, 4'd15, 2'd2);
    step(31);
    check_all("fo_e31", 1'b1, 4'd12, 2'd2);
    step(1);
`ifdef VREQ_MAXOUT_EN
    check_all("fo_out", 1'b0, 4'd11, 2'd3);
    bus.cntry_road_signal = RED;
    step(16);
    check_all("fo_idle", 1'b0, 4'd11, 2'd0);
    step(1);
    check_all("fo_rereq", 1'b1, 4'd11, 2'd1);
`else
    check_all("fo_hold", 1'b1, 4'd11, 2'd2);
    step(88);
    check_all("fo_empty", 1'b1, 4'd0, 2'd2);
    step(1);
    check_all("fo_rearm", 1'b0, 4'd0, 2'd3);
    bus.cntry_road_signal = RED;
    step(16);
    check_all("fo_idle", 1'b0, 4'd0, 2'd0);
`endif

    // Reset asserted between edges clears outputs without a clock.
    reset_n = 1'b0;
    #2;
    check_all("async_rst1", 1'b0, 4'd0, 2'd0);
    do_reset();

    // Simultaneity: arrival lands on the first drain edge (entry + 8).
    arrive_one();
    arrive_one();
    check_all("sim_setup", 1'b1, 4'd2, 2'd1);
    bus.cntry_road_signal = GREEN;
    step(1);
    check_all("sim_entry", 1'b1, 4'd2, 2'd2);
    step(2);
    bus.loop_raw = 1'b1;
    step(5);
    check_all("sim_pre", 1'b1, 4'd2, 2'd2);
    step(1);
    check_all("sim_edge", 1'b1, 4'd2, 2'd2);
    bus.loop_raw = 1'b0;
    step(8);
    check_all("sim_drain2", 1'b1, 4'd1, 2'd2);

    // Reset asserted mid-SERVE with a nonzero queue.
    reset_n = 1'b0;
    #2;
    check_all("async_rst2", 1'b0, 4'd0, 2'd0);
    step(2);
    check_all("rst_held", 1'b0, 4'd0, 2'd0);
    reset_n = 1'b1;
    bus.cntry_road_signal = RED;
    step(3);
    check_all("rst_release", 1'b0, 4'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vehicle_request_gen.md
# vehicle_request_gen

Country-road vehicle detector and request generator. Conditions the raw inductive-loop sensor, counts waiting vehicles, and drives the single-bit request `x` consumed by the highway/country-road signal controller directly downstream. It watches the controller's country-road signal to decide when the queue is served, when to withdraw the request, and how long to stay quiet before requesting again.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive synchronized samples required to accept a sensor level change (≥1).
- `DRAIN_CYCLES`, 8: country-green cycles per vehicle discharged from the queue (≥1).
- `MAX_GREEN`, 32: maximum SERVE cycles before force-out (≥1; used only with `VREQ_MAXOUT_EN`).
- `REARM_CYCLES`, 16: cycles in REARM before a new request may assert (≥1).
- `CNT_W`, 4: width of the pending-vehicle counter.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `loop_raw` input 1: raw loop sensor, asynchronous to `clk`, high = vehicle present.
- `cntry_road_signal` input 2: controller's country-road lamp. Encoding: red=2'b00, yellow=2'b01, green=2'b10.
- `x` output 1: vehicle request to the signal controller.
- `pending` output CNT_W: vehicles waiting.
- `state_out` output 2: FSM state. IDLE=0, REQ=1, SERVE=2, REARM=3.

## Operation
- **Synchronizer:** two flops on `loop_raw`, producing `s2`.
- **Debounce:**
  - Counter increments while `s2 != filt`, and clears when `s2 == filt`.
  - When the count reaches `DEB_CYCLES`, `filt <= s2` and the counter clears.
- **Arrival:** a `filt` 0→1 update increments `pending` on that same edge. Arrivals are accepted in every state.
- **Drain timer:** runs only in SERVE.
  - On reaching `DRAIN_CYCLES-1` it wraps to 0, and `pending` decrements if nonzero.
  - Cleared on SERVE entry.
- **Counter arithmetic:**
  - Arrival and drain on the same edge: `pending` unchanged.
  - Saturates at 2^CNT_W−1; further arrivals are dropped.
  - Never underflows.
- **FSM** (Moore; `x`=1 in REQ and SERVE only):
  - IDLE: `pending != 0` → REQ.
  - REQ: `cntry_road_signal == green` → SERVE. Serve timer and drain timer clear.
  - SERVE:
    - `pending == 0` (registered value) → REARM.
    - `cntry_road_signal != green` → REARM.
    - Serve timer reaches `MAX_GREEN-1` → REARM (macro-dependent).
  - REARM: counts `REARM_CYCLES`; at `REARM_CYCLES-1` → IDLE.
- **Green at IDLE:** green seen while in IDLE is ignored; no SERVE without a prior REQ.
- **Reset** (asynchronous, any time, including mid-SERVE):
  - State IDLE.
  - `x`=0, `pending`=0, `state_out`=0.
  - `filt`=0, sync flops=0, all timers=0.

## Timing
- Arrival latency, `loop_raw` rising before edge k:
  - `s2` high after edge k+1.
  - `filt` and `pending` update at edge k+1+DEB_CYCLES.
  - `x` rises at edge k+2+DEB_CYCLES.
- REQ→SERVE occurs on the first edge sampling green; `x` stays high throughout.
- A drain occurs every `DRAIN_CYCLES` edges in SERVE; the first drain is at the `DRAIN_CYCLES`-th edge after entry.
- SERVE exit on an empty queue occurs one edge after `pending` becomes 0; `x` falls on that same edge.
- REARM lasts exactly `REARM_CYCLES` cycles, then IDLE. If `pending != 0`, REQ follows on the next edge.
- Pulses on `loop_raw` shorter than `DEB_CYCLES` synchronized cycles are rejected.

## Configuration
- `VREQ_MAXOUT_EN` defined:
  - The SERVE serve timer is present.
  - Force-out to REARM at `MAX_GREEN` cycles, leaving the residual `pending` intact.
- Not defined:
  - No serve timer.
  - SERVE exits only on an empty queue or loss of green.
  - `MAX_GREEN` is unused.

## Test plan
All scenarios use defaults: DEB=4, DRAIN=8, MAX=32, REARM=16, CNT_W=4.
- **Reset values:** assert `reset_n`=0 mid-sequence → `x`=0, `pending`=0, `state_out`=0 immediately, without waiting for a clock edge.
- **Glitch rejection:** `loop_raw` high for 3 cycles → `filt` and `pending` stay 0, `x` stays 0.
- **Single vehicle:** `loop_raw` high for 10 cycles → `pending`=1 at edge k+5, `x`=1 at edge k+6. Then drive green → SERVE; after 8 cycles `pending`=0; the next edge gives REARM with `x`=0; IDLE 16 cycles later.
- **Saturation:** 20 debounced arrivals in IDLE/REQ with no green → `pending`=15 and holds.
- **Simultaneity:** arrival coincident with a drain edge → `pending` unchanged.
- **Force-out:** `pending`=15, green held.
  - With `VREQ_MAXOUT_EN`: `x` drops after 32 SERVE cycles with `pending`=11, then re-requests after REARM.
  - Without the macro: `x` holds for 120 cycles until `pending`=0.
